conv1d_window_ram: RTL

CONV1D_WINDOW_RAM -- requirements
Module: conv1d_window_ram

---
 rtl/conv1d_pkg.sv | 7 +
 rtl/conv1d_bank_ram.sv | 31 +++
 rtl/conv1d_window_ram.sv | 113 +++++++++++
 3 files changed

// File: rtl/conv1d_pkg.sv
// Shared constants for the conv1d window RAM: default sample width and
// edge-padding mode codes.
package conv1d_pkg;
    localparam int DEFAULT_BIT_WIDTH = 16;
    localparam int PAD_ZERO          = 0;
    localparam int PAD_REPLICATE     = 1;
endpackage

// File: rtl/conv1d_bank_ram.sv
// One channel bank: single synchronous write port, three asynchronous read
// ports. Contents are deliberately not reset.
module conv1d_bank_ram
    import conv1d_pkg::*;
#(
    parameter int Bit_width = DEFAULT_BIT_WIDTH,
    parameter int Length    = 256
) (
    input  logic                          CLK,
    input  logic                          write_en,
    input  logic [$clog2(Length)-1:0]     write_addr,
    input  logic signed [Bit_width-1:0]   write_data,
    input  logic [$clog2(Length)-1:0]     read_addr_0,
    input  logic [$clog2(Length)-1:0]     read_addr_1,
    input  logic [$clog2(Length)-1:0]     read_addr_2,
    output logic signed [Bit_width-1:0]   read_data_0,
    output logic signed [Bit_width-1:0]   read_data_1,
    output logic signed [Bit_width-1:0]   read_data_2
);
    logic signed [Bit_width-1:0] mem [Length];

    always_ff @(posedge CLK) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    assign read_data_0 = mem[read_addr_0];
    assign read_data_1 = mem[read_addr_1];
    assign read_data_2 = mem[read_addr_2];
endmodule

// File: rtl/conv1d_window_ram.sv
// Multi-channel sample store returning a 3-tap window (centre-1/centre/centre+1)
// one cycle after a read request, with edge padding and same-cycle write forwarding.
module conv1d_window_ram
    import conv1d_pkg::*;
#(
    parameter int Bit_width = DEFAULT_BIT_WIDTH,
    parameter int Channels  = 16,
    parameter int Length    = 256,
    parameter int Pad_Mode  = PAD_ZERO
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          Write_Enable,
    input  logic [$clog2(Channels)-1:0]   Write_Channel,
    input  logic [$clog2(Length)-1:0]     Write_Index,
    input  logic signed [Bit_width-1:0]   data_in,
    input  logic                          Read_Enable,
    input  logic [$clog2(Channels)-1:0]   Read_Channel,
    input  logic [$clog2(Length)-1:0]     Read_Index,
    output logic signed [Bit_width-1:0]   data_out_0,
    output logic signed [Bit_width-1:0]   data_out_1,
    output logic signed [Bit_width-1:0]   data_out_2,
    output logic                          Read_Valid,
    output logic                          Range_Error
);
    localparam int CW = $clog2(Channels);
    localparam int IW = $clog2(Length);
    // One extra bit so Channels/Length themselves are representable as limits.
    localparam logic [CW:0]   CH_LIMIT  = (CW+1)'(Channels);
    localparam logic [IW:0]   IDX_LIMIT = (IW+1)'(Length);
    localparam logic [IW-1:0] IDX_LAST  = IW'(Length - 1);

    logic wr_in_range, rd_in_range, wr_ok, wr_err, rd_err;

    assign wr_in_range = ({1'b0, Write_Channel} < CH_LIMIT) && ({1'b0, Write_Index} < IDX_LIMIT);
    assign rd_in_range = ({1'b0, Read_Channel} < CH_LIMIT) && ({1'b0, Read_Index} < IDX_LIMIT);
    assign wr_ok       = Write_Enable && wr_in_range && RST_N;
    assign wr_err      = Write_Enable && !wr_in_range;
    assign rd_err      = Read_Enable && !rd_in_range;

    // Stage p0: tap addresses clamped at the edges, bank read, forward, pad
    logic [CW-1:0] rd_ch_p0;
    logic [IW-1:0] addr_m1_p0, addr_c_p0, addr_p1_p0;
    logic          at_first_p0, at_last_p0;

    always_comb begin
        rd_ch_p0    = rd_in_range ? Read_Channel : '0;
        addr_c_p0   = rd_in_range ? Read_Index : '0;
        at_first_p0 = (addr_c_p0 == '0);
        at_last_p0  = (addr_c_p0 == IDX_LAST);
        addr_m1_p0  = at_first_p0 ? addr_c_p0 : addr_c_p0 - IW'(1);
        addr_p1_p0  = at_last_p0 ? addr_c_p0 : addr_c_p0 + IW'(1);
    end

    logic signed [Bit_width-1:0] bank_q0 [Channels];
    logic signed [Bit_width-1:0] bank_q1 [Channels];
    logic signed [Bit_width-1:0] bank_q2 [Channels];

    for (genvar g = 0; g < Channels; g++) begin : g_bank
        conv1d_bank_ram #(
            .Bit_width (Bit_width),
            .Length    (Length)
        ) u_bank (
            .CLK         (CLK),
            .write_en    (wr_ok && (Write_Channel == CW'(g))),
            .write_addr  (Write_Index),
            .write_data  (data_in),
            .read_addr_0 (addr_m1_p0),
            .read_addr_1 (addr_c_p0),
            .read_addr_2 (addr_p1_p0),
            .read_data_0 (bank_q0[g]),
            .read_data_1 (bank_q1[g]),
            .read_data_2 (bank_q2[g])
        );
    end

    logic                        fwd_ch_p0;
    logic signed [Bit_width-1:0] tap0_p0, tap1_p0, tap2_p0;

    always_comb begin
        fwd_ch_p0 = wr_ok && (Write_Channel == rd_ch_p0);
        tap0_p0   = (fwd_ch_p0 && Write_Index == addr_m1_p0) ? data_in : bank_q0[rd_ch_p0];
        tap1_p0   = (fwd_ch_p0 && Write_Index == addr_c_p0)  ? data_in : bank_q1[rd_ch_p0];
        tap2_p0   = (fwd_ch_p0 && Write_Index == addr_p1_p0) ? data_in : bank_q2[rd_ch_p0];
        // Replicate mode gets its edge sample for free from the clamped address.
        if (Pad_Mode == PAD_ZERO && at_first_p0) tap0_p0 = '0;
        if (Pad_Mode == PAD_ZERO && at_last_p0)  tap2_p0 = '0;
        if (!rd_in_range) begin
            tap0_p0 = '0;
            tap1_p0 = '0;
            tap2_p0 = '0;
        end
    end

    // Stage p1: registered window, valid and error flag
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            data_out_0  <= '0;
            data_out_1  <= '0;
            data_out_2  <= '0;
            Read_Valid  <= 1'b0;
            Range_Error <= 1'b0;
        end else begin
            Read_Valid  <= Read_Enable;
            Range_Error <= rd_err || wr_err;
            if (Read_Enable) begin
                data_out_0 <= tap0_p0;
                data_out_1 <= tap1_p0;
                data_out_2 <= tap2_p0;
            end
        end
    end
endmodule
